ticket_bill_feeder: RTL and testbench

- Front-end driver for the ticket vending FSM: accepts validated bills from the bill reader, buffers them, and presents each one to the vending FSM as a single-cycle ten/twenty pulse.
- Watches the vending FSM's Moore outputs (ready, bill, dispense, return_sig) and drives the ticket-vend and bill-eject motors for fixed durations.
- Sits between the bill reader and the vending FSM, on the same clock domain.

---
 rtl/ticket_bill_feeder.sv | 190 +++++++++++++++++++
 tb/tb_ticket_bill_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_bill_feeder.sv
// ticket_bill_feeder
//   Front end for the ticket vending FSM. Validated bills from the bill reader
//   go into a small FIFO. Each bill is then presented to the vending FSM as a
//   single-cycle ten/twenty pulse. The feeder also watches the vending FSM's
//   Moore outputs and drives the ticket-vend and bill-eject motors for fixed
//   durations.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | wait for dispense / return_sig / a buffered bill to issue
//   ISSUE  | ten or twenty pulse is high this cycle; FIFO head already popped
//   SETTLE | quiet cycle so the vending FSM can register the pulse
//   VEND   | vend motor on, counts down VEND_CYCLES
//   EJECT  | eject motor on, counts down EJECT_CYCLES
//
// Ports
//   clk          system clock, rising edge
//   clear_n      asynchronous active-low reset
//   bill_valid   reader offers a bill this cycle
//   bill_denom   0 = ten, 1 = twenty (qualified by bill_valid)
//   bill_accept  feeder can take a bill (combinational, from registered state)
//   ready        vending FSM in ready state
//   bill         vending FSM in a bill-accumulating state
//   dispense     vending FSM in dispense state
//   return_sig   vending FSM in return state
//   ten          one-cycle pulse, ten-unit bill delivered
//   twenty       one-cycle pulse, twenty-unit bill delivered
//   vend         ticket motor drive
//   eject        bill-return motor drive
//   credit       ten-units delivered since last dispense/return (saturates at 7)
//   err          sticky protocol error
module ticket_bill_feeder #(
    parameter int FIFO_DEPTH   = 2,
    parameter int VEND_CYCLES  = 4,
    parameter int EJECT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       bill_valid,
    input  logic       bill_denom,
    output logic       bill_accept,
    input  logic       ready,
    input  logic       bill,
    input  logic       dispense,
    input  logic       return_sig,
    output logic       ten,
    output logic       twenty,
    output logic       vend,
    output logic       eject,
    output logic [2:0] credit,
    output logic       err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (VEND_CYCLES > EJECT_CYCLES) ? VEND_CYCLES : EJECT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        VEND   = 3'd3,
        EJECT  = 3'd4
    } state_t;

    state_t               state;
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [TW-1:0]        timer;
    logic                 rst_done;

    logic                 full;
    logic                 empty;
    logic                 head;
    logic                 push;
    logic                 pop;
    logic [3:0]           credit_sum;
    logic [2:0]           credit_issue;
    logic                 err_hit;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign head        = mem[rd_ptr];
    // Held low until the first clock after reset release.
    assign bill_accept = rst_done && !full;
    assign push        = bill_valid && bill_accept;

    // The pop happens on the edge that enters ISSUE, so the pulse is
    // registered from the head value in the same edge.
    assign pop = (state == IDLE) && !dispense && !return_sig &&
                 !empty && (ready || bill);

    assign credit_sum   = {1'b0, credit} + (head ? 4'd2 : 4'd1);
    assign credit_issue = (credit_sum > 4'd7) ? 3'd7 : credit_sum[2:0];

    assign err_hit = (dispense && return_sig) || (ready && bill) ||
                     (pop && (credit_sum > 4'd5));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bill_denom;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            ten      <= 1'b0;
            twenty   <= 1'b0;
            vend     <= 1'b0;
            eject    <= 1'b0;
            credit   <= 3'd0;
            err      <= 1'b0;
            timer    <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            ten      <= 1'b0;
            twenty   <= 1'b0;
            if (err_hit) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dispense) begin
                        state  <= VEND;
                        vend   <= 1'b1;
                        credit <= 3'd0;
                        timer  <= TW'(VEND_CYCLES - 1);
                    end else if (return_sig) begin
                        state  <= EJECT;
                        eject  <= 1'b1;
                        credit <= 3'd0;
                        timer  <= TW'(EJECT_CYCLES - 1);
                    end else if (pop) begin
                        state  <= ISSUE;
                        ten    <= !head;
                        twenty <= head;
                        credit <= credit_issue;
                    end
                end
                ISSUE: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= IDLE;
                end
                VEND: begin
                    if (timer == '0) begin
                        vend  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                EJECT: begin
                    if (timer == '0) begin
                        eject <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ticket_bill_feeder.sv
// Directed bench for ticket_bill_feeder. The vending FSM's outputs are driven
// by hand at each step; expected values are worked out cycle by cycle.
module tb_ticket_bill_feeder;

    logic       clk;
    logic       clear_n;
    logic       bill_valid;
    logic       bill_denom;
    logic       bill_accept;
    logic       ready;
    logic       bill;
    logic       dispense;
    logic       return_sig;
    logic       ten;
    logic       twenty;
    logic       vend;
    logic       eject;
    logic [2:0] credit;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    ticket_bill_feeder #(
        .FIFO_DEPTH  (2),
        .VEND_CYCLES (4),
        .EJECT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .bill_valid (bill_valid),
        .bill_denom (bill_denom),
        .bill_accept(bill_accept),
        .ready      (ready),
        .bill       (bill),
        .dispense   (dispense),
        .return_sig (return_sig),
        .ten        (ten),
        .twenty     (twenty),
        .vend       (vend),
        .eject      (eject),
        .credit     (credit),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        clear_n    = 1'b0;
        bill_valid = 1'b0;
        bill_denom = 1'b0;
        ready      = 1'b0;
        bill       = 1'b0;
        dispense   = 1'b0;
        return_sig = 1'b0;
        #3;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        // ---- reset state
        reset_dut();
        check("rst_ten", 8'(ten), 8'd0);
        check("rst_twenty", 8'(twenty), 8'd0);
        check("rst_vend", 8'(vend), 8'd0);
        check("rst_eject", 8'(eject), 8'd0);
        check("rst_credit", 8'(credit), 8'd0);
        check("rst_err", 8'(err), 8'd0);
        step();
        check("rst_accept", 8'(bill_accept), 8'd1);

        // ---- one ten bill, vending FSM ready
        ready      = 1'b1;
        bill_valid = 1'b1;
        bill_denom = 1'b0;
        step();                              // handshake edge
        bill_valid = 1'b0;
        check("t1_ten_early", 8'(ten), 8'd0);
        step();                              // enter ISSUE
        check("t1_ten", 8'(ten), 8'd1);
        check("t1_twenty", 8'(twenty), 8'd0);
        check("t1_credit", 8'(credit), 8'd1);
        step();
        check("t1_ten_one_cycle", 8'(ten), 8'd0);

        // ---- two twenties, FIFO fills, then dispense
        reset_dut();
        step();
        ready      = 1'b0;
        bill_valid = 1'b1;
        bill_denom = 1'b1;
        step();
        check("t2_accept_1", 8'(bill_accept), 8'd1);
        step();
        check("t2_accept_full", 8'(bill_accept), 8'd0);
        bill_valid = 1'b0;
        ready      = 1'b1;
        step();
        check("t2_twenty_a", 8'(twenty), 8'd1);
        check("t2_ten_a", 8'(ten), 8'd0);
        check("t2_credit_a", 8'(credit), 8'd2);
        check("t2_accept_after_pop", 8'(bill_accept), 8'd1);
        step();
        check("t2_settle", 8'(twenty), 8'd0);
        step();
        check("t2_idle", 8'(twenty), 8'd0);
        step();
        check("t2_twenty_b", 8'(twenty), 8'd1);
        check("t2_credit_b", 8'(credit), 8'd4);
        step();
        step();
        ready    = 1'b0;
        dispense = 1'b1;
        step();
        dispense = 1'b0;
        check("t2_vend_1", 8'(vend), 8'd1);
        check("t2_credit_clr", 8'(credit), 8'd0);
        step();
        check("t2_vend_2", 8'(vend), 8'd1);
        step();
        check("t2_vend_3", 8'(vend), 8'd1);
        step();
        check("t2_vend_4", 8'(vend), 8'd1);
        step();
        check("t2_vend_off", 8'(vend), 8'd0);
        check("t2_err", 8'(err), 8'd0);

        // ---- bills 10, 20, 20 with return
        reset_dut();
        step();
        bill_valid = 1'b1;
        bill_denom = 1'b0;
        step();                              // push 10
        bill_denom = 1'b1;
        step();                              // push 20, full
        check("t3_full", 8'(bill_accept), 8'd0);
        ready = 1'b1;
        step();                              // ISSUE ten; third bill pushed next edge
        check("t3_ten", 8'(ten), 8'd1);
        check("t3_credit_a", 8'(credit), 8'd1);
        step();
        bill_valid = 1'b0;
        step();
        step();                              // ISSUE twenty
        check("t3_twenty", 8'(twenty), 8'd1);
        check("t3_credit_b", 8'(credit), 8'd3);
        ready = 1'b0;
        step();
        step();                              // back in IDLE
        return_sig = 1'b1;
        step();
        return_sig = 1'b0;
        check("t3_eject_1", 8'(eject), 8'd1);
        check("t3_credit_clr", 8'(credit), 8'd0);
        step();
        check("t3_eject_2", 8'(eject), 8'd1);
        check("t3_no_issue_in_eject", 8'(twenty), 8'd0);
        step();
        check("t3_eject_3", 8'(eject), 8'd1);
        step();
        check("t3_eject_4", 8'(eject), 8'd1);
        step();
        check("t3_eject_off", 8'(eject), 8'd0);
        check("t3_held", 8'(twenty), 8'd0);
        ready = 1'b1;
        step();
        check("t3_third", 8'(twenty), 8'd1);
        check("t3_credit_c", 8'(credit), 8'd2);

        // ---- bill waits while vending FSM neither ready nor accumulating
        reset_dut();
        step();
        bill_valid = 1'b1;
        bill_denom = 1'b0;
        step();
        bill_valid = 1'b0;
        step();
        check("t4_wait_a", 8'(ten), 8'd0);
        step();
        check("t4_wait_b", 8'(ten), 8'd0);
        ready = 1'b1;
        step();
        check("t4_ten", 8'(ten), 8'd1);
        check("t4_err_clean", 8'(err), 8'd0);
        bill = 1'b1;
        step();
        bill  = 1'b0;
        ready = 1'b0;
        check("t4_err_ready_bill", 8'(err), 8'd1);

        // ---- dispense and return together: err, VEND wins
        reset_dut();
        step();
        dispense   = 1'b1;
        return_sig = 1'b1;
        step();
        dispense   = 1'b0;
        return_sig = 1'b0;
        check("t5_err", 8'(err), 8'd1);
        check("t5_vend", 8'(vend), 8'd1);
        check("t5_eject", 8'(eject), 8'd0);
        step();
        step();
        step();
        check("t5_vend_4", 8'(vend), 8'd1);
        step();
        check("t5_vend_off", 8'(vend), 8'd0);
        check("t5_err_sticky", 8'(err), 8'd1);

        // ---- credit overflow and saturation
        reset_dut();
        step();
        ready      = 1'b1;
        bill_valid = 1'b1;
        bill_denom = 1'b1;
        step();                              // P1 push
        step();                              // P2 issue #1
        check("t7_credit_2", 8'(credit), 8'd2);
        step();
        step();
        step();                              // P5 issue #2
        check("t7_credit_4", 8'(credit), 8'd4);
        check("t7_err_none", 8'(err), 8'd0);
        step();
        step();
        step();                              // P8 issue #3
        check("t7_credit_6", 8'(credit), 8'd6);
        check("t7_err_over", 8'(err), 8'd1);
        step();
        step();
        step();                              // P11 issue #4
        check("t7_credit_sat", 8'(credit), 8'd7);
        bill_valid = 1'b0;
        ready      = 1'b0;

        // ---- reset mid-VEND
        reset_dut();
        step();
        bill_valid = 1'b1;
        bill_denom = 1'b0;
        step();                              // one bill buffered
        bill_valid = 1'b0;
        dispense   = 1'b1;
        step();
        dispense = 1'b0;
        step();                              // second vend cycle
        check("t6_vend_pre", 8'(vend), 8'd1);
        #2;
        clear_n = 1'b0;
        #1;
        check("t6_vend_async", 8'(vend), 8'd0);
        check("t6_credit_async", 8'(credit), 8'd0);
        @(negedge clk);
        clear_n = 1'b1;
        ready   = 1'b1;
        step();
        check("t6_accept", 8'(bill_accept), 8'd1);
        step();
        step();
        check("t6_fifo_empty", 8'(ten), 8'd0);
        check("t6_vend_idle", 8'(vend), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
